pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It resolves load-use hazards, taken branches, multi-cycle EX operations (divider), data-memory wait and exceptions/ERET. It drives the per-register stall_C/flush_C vectors consumed by all pipeline registers, plus the PC redirect. It sits beside the decode/execute datapath and is the only source of stall_C/flush_C.

Parameters:
MC_CYCLES, 32, total EX occupancy in cycles of a multi-cycle op (legal range 2..63)
EXC_VECTOR, 32'hBFC00380, exception entry PC

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
load_use_req  in  1  ID detects a load-use dependency on the EX-stage load
branch_taken  in  1  ID resolved a taken branch/jump
branch_target  in  32  target PC for branch_taken
mc_start  in  1  EX holds a multi-cycle op (level, valid while the op sits in EX)
mem_wait  in  1  data memory not ready in MEM
exc_req  in  1  MEM-stage instruction raises an exception
eret_req  in  1  MEM-stage instruction is ERET
epc_in  in  32  EPC from CP0
stall_C  out  4  hold per register: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM
stall_mw  out  1  hold MEM/WB
flush_C  out  4  flush per register, same bit mapping
pc_redirect  out  1  PC loads redirect_pc at the next edge
redirect_pc  out  32  redirect target
mc_done  out  1  multi-cycle op completes this cycle
mc_abort  out  1  multi-cycle op killed by exception
exc_commit  out  1  exception/ERET accepted this cycle

Behaviour:
- Register convention: a register with stall_C[k]=1 and stall_C[k+1]=0 (stall_C[4] is implicitly stall_mw) loads a bubble. Legal stall patterns are 0000, 0111 and 1111. Flush has priority over stall inside every register.
- States: RUN, MC_WAIT (6-bit down-counter cnt), EXC_DRAIN.
- Outputs are combinational from state, cnt and the current inputs. Defaults: all outputs 0, redirect_pc = 0.
- Reset (rst low, asynchronous): state RUN, cnt 0. All outputs 0, including redirect_pc.
- RUN priority, highest first:
  1. exc_req | eret_req:
     - flush_C=1110, stall_C=0000, pc_redirect=1, exc_commit=1.
     - redirect_pc = epc_in when eret_req, else EXC_VECTOR. exc_req wins if both are set.
     - next state EXC_DRAIN.
  2. mem_wait: stall_C=1111, stall_mw=1.
  3. mc_start: stall_C=1111, cnt<=MC_CYCLES-2, next state MC_WAIT.
  4. load_use_req: stall_C=0111. Any simultaneous branch_taken is ignored; ID re-evaluates the branch next cycle.
  5. branch_taken: flush_C=0010, pc_redirect=1, redirect_pc=branch_target.
- MC_WAIT:
  - exc_req|eret_req: same outputs as RUN case 1, plus mc_abort=1, cnt<=0, next state EXC_DRAIN.
  - else if cnt!=0: stall_C=1111, stall_mw=mem_wait, cnt<=cnt-1 (the counter runs even during mem_wait).
  - else (cnt==0): mc_done=1.
    - if mem_wait: stall_C=1111, stall_mw=1, stay in MC_WAIT.
    - otherwise: stall_C=0000, next state RUN.
  - Result: EX occupancy is exactly MC_CYCLES cycles without mem_wait. mc_start is ignored while in MC_WAIT.
- EXC_DRAIN: lasts exactly 1 cycle. exc_req, eret_req and mc_start are ignored. mem_wait, load_use_req and branch_taken are handled as in RUN. Next state RUN.
- Reset mid-MC_WAIT: the op is abandoned silently, with no mc_abort pulse.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments in each cycle where stall_C!=0.
  - flush_events increments in each cycle where flush_C!=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and the counter logic are absent. Nothing else changes.

Test Plan:
1. Load-use: load_use_req=1 for 1 cycle with branch_taken=1 -> stall_C=0111, flush_C=0000, pc_redirect=0. Next cycle branch_taken=1 alone, branch_target=32'h00400020 -> flush_C=0010, redirect_pc=32'h00400020.
2. Divider, MC_CYCLES=32: mc_start held -> stall_C=1111 for 31 consecutive cycles. mc_done=1 with stall_C=0000 on the 32nd cycle, then state RUN.
3. mem_wait=1 for 3 cycles overlapping cnt reaching 0 in MC_WAIT -> stall_mw=1 and mc_done held high until mem_wait drops. Stall released in the same cycle mem_wait drops.
4. exc_req at MC_WAIT cnt=10 -> flush_C=1110, redirect_pc=32'hBFC00380, mc_abort=1, exc_commit=1. A second exc_req in the following cycle is ignored (EXC_DRAIN).
5. eret_req with epc_in=32'h00400100 in RUN -> redirect_pc=32'h00400100. Same cycle with exc_req also set -> redirect_pc=EXC_VECTOR.
6. rst pulled low mid-MC_WAIT -> all outputs 0 immediately, asynchronously. After release, mc_start -> fresh 31-cycle stall. With PIPE_PERF_CNT_EN defined, stall_cycles=31 after that op.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, taken branches, multi-cycle EX ops, data-memory
// wait and exceptions/ERET, and drives the PC redirect.
// Optional feature: define PIPE_PERF_CNT_EN to add the stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_CYCLES  = 32,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mc_start,
  input  logic        mem_wait,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
  output logic [3:0]  stall_C,
  output logic        stall_mw,
  output logic [3:0]  flush_C,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        mc_done,
  output logic        mc_abort,
  output logic        exc_commit
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam logic [1:0] StRun      = 2'd0;
  localparam logic [1:0] StMcWait   = 2'd1;
  localparam logic [1:0] StExcDrain = 2'd2;

  localparam logic [5:0] McLoad = 6'(MC_CYCLES - 2);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        exc_any;
  logic [31:0] exc_pc;

  assign exc_any = exc_req | eret_req;
  // exc_req wins over eret_req when both are raised.
  assign exc_pc  = exc_req ? EXC_VECTOR : epc_in;

  // Next-state and all hazard outputs; everything forced to 0 while in reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_C     = 4'b0000;
    stall_mw    = 1'b0;
    flush_C     = 4'b0000;
    pc_redirect = 1'b0;
    redirect_pc = 32'h0;
    mc_done     = 1'b0;
    mc_abort    = 1'b0;
    exc_commit  = 1'b0;
    if (rst) begin
      unique case (state_q)
        StMcWait: begin
          if (exc_any) begin
            flush_C     = 4'b1110;
            pc_redirect = 1'b1;
            redirect_pc = exc_pc;
            exc_commit  = 1'b1;
            mc_abort    = 1'b1;
            cnt_d       = 6'd0;
            state_d     = StExcDrain;
          end else if (cnt_q != 6'd0) begin
            // Counter keeps running through mem_wait.
            stall_C  = 4'b1111;
            stall_mw = mem_wait;
            cnt_d    = cnt_q - 6'd1;
          end else begin
            mc_done = 1'b1;
            if (mem_wait) begin
              stall_C  = 4'b1111;
              stall_mw = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
        end
        StExcDrain: begin
          // One-cycle shadow: new exceptions and mc_start are ignored.
          state_d = StRun;
          if (mem_wait) begin
            stall_C  = 4'b1111;
            stall_mw = 1'b1;
          end else if (load_use_req) begin
            stall_C = 4'b0111;
          end else if (branch_taken) begin
            flush_C     = 4'b0010;
            pc_redirect = 1'b1;
            redirect_pc = branch_target;
          end
        end
        default: begin
          state_d = StRun;
          if (exc_any) begin
            flush_C     = 4'b1110;
            pc_redirect = 1'b1;
            redirect_pc = exc_pc;
            exc_commit  = 1'b1;
            state_d     = StExcDrain;
          end else if (mem_wait) begin
            stall_C  = 4'b1111;
            stall_mw = 1'b1;
          end else if (mc_start) begin
            stall_C = 4'b1111;
            cnt_d   = McLoad;
            state_d = StMcWait;
          end else if (load_use_req) begin
            // Branch in ID is dropped; it is re-evaluated next cycle.
            stall_C = 4'b0111;
          end else if (branch_taken) begin
            flush_C     = 4'b0010;
            pc_redirect = 1'b1;
            redirect_pc = branch_target;
          end
        end
      endcase
    end
  end

  // State and multi-cycle counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'h0;
      flush_events <= 32'h0;
    end else begin
      if (stall_C != 4'b0000) stall_cycles <= stall_cycles + 32'h1;
      if (flush_C != 4'b0000) flush_events <= flush_events + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MC      = 32;
  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use_req, branch_taken, mc_start, mem_wait, exc_req, eret_req;
  logic [31:0] branch_target, epc_in;
  logic [3:0]  stall_C, flush_C;
  logic        stall_mw, pc_redirect, mc_done, mc_abort, exc_commit;
  logic [31:0] redirect_pc;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MC_CYCLES (MC),
    .EXC_VECTOR(EXC_VEC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use_req (load_use_req),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mc_start     (mc_start),
    .mem_wait     (mem_wait),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc_in       (epc_in),
    .stall_C      (stall_C),
    .stall_mw     (stall_mw),
    .flush_C      (flush_C),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .mc_done      (mc_done),
    .mc_abort     (mc_abort),
    .exc_commit   (exc_commit)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an op in EX is tracked by how many cycles it has spent there.
  bit          m_in_mc, m_drain;
  int          m_elapsed;
  int unsigned m_sc, m_fe;
  logic [3:0]  e_stall, e_flush;
  logic        e_mw, e_redir, e_done, e_abort, e_commit;
  logic [31:0] e_pc;
  bit          n_in_mc, n_drain;
  int          n_elapsed;

  task automatic model_reset();
    m_in_mc = 0; m_drain = 0; m_elapsed = 0; m_sc = 0; m_fe = 0;
  endtask

  task automatic take_exception();
    e_flush = 4'b1110; e_redir = 1; e_commit = 1;
    e_pc = exc_req ? EXC_VEC : epc_in;
    n_drain = 1;
  endtask

  task automatic model_eval();
    e_stall = 0; e_flush = 0; e_mw = 0; e_redir = 0; e_done = 0; e_abort = 0;
    e_commit = 0; e_pc = 0;
    n_in_mc = m_in_mc; n_drain = 0; n_elapsed = m_elapsed;
    if (m_in_mc) begin
      if (exc_req || eret_req) begin
        take_exception();
        e_abort = 1; n_in_mc = 0;
      end else if (m_elapsed + 1 < MC) begin
        e_stall = 4'hF; e_mw = mem_wait; n_elapsed = m_elapsed + 1;
      end else begin
        e_done = 1;
        if (mem_wait) begin
          e_stall = 4'hF; e_mw = 1;
        end else begin
          n_in_mc = 0;
        end
      end
    end else if (!m_drain && (exc_req || eret_req)) begin
      take_exception();
    end else if (mem_wait) begin
      e_stall = 4'hF; e_mw = 1;
    end else if (!m_drain && mc_start) begin
      e_stall = 4'hF; n_in_mc = 1; n_elapsed = 1;
    end else if (load_use_req) begin
      e_stall = 4'b0111;
    end else if (branch_taken) begin
      e_flush = 4'b0010; e_redir = 1; e_pc = branch_target;
    end
  endtask

  task automatic check_outputs();
    check_eq("stall_C", 64'(stall_C), 64'(e_stall));
    check_eq("stall_mw", 64'(stall_mw), 64'(e_mw));
    check_eq("flush_C", 64'(flush_C), 64'(e_flush));
    check_eq("pc_redirect", 64'(pc_redirect), 64'(e_redir));
    check_eq("redirect_pc", 64'(redirect_pc), 64'(e_pc));
    check_eq("mc_done", 64'(mc_done), 64'(e_done));
    check_eq("mc_abort", 64'(mc_abort), 64'(e_abort));
    check_eq("exc_commit", 64'(exc_commit), 64'(e_commit));
`ifdef PIPE_PERF_CNT_EN
    check_eq("stall_cycles", 64'(stall_cycles), 64'(m_sc));
    check_eq("flush_events", 64'(flush_events), 64'(m_fe));
`endif
  endtask

  // One clock cycle: drive after negedge, check before posedge, advance model.
  task automatic apply(input logic lu, input logic bt, input logic [31:0] bta, input logic mc,
                       input logic mw, input logic ex, input logic er, input logic [31:0] epc);
    @(negedge clk);
    load_use_req = lu; branch_taken = bt; branch_target = bta; mc_start = mc;
    mem_wait = mw; exc_req = ex; eret_req = er; epc_in = epc;
    #1;
    model_eval();
    check_outputs();
    if (e_stall != 0) m_sc++;
    if (e_flush != 0) m_fe++;
    m_in_mc = n_in_mc; m_drain = n_drain; m_elapsed = n_elapsed;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 64'({stall_C, stall_mw}), 64'h0);
    check_eq({tag, "_flush"}, 64'(flush_C), 64'h0);
    check_eq({tag, "_redir"}, 64'({pc_redirect, redirect_pc}), 64'h0);
    check_eq({tag, "_flags"}, 64'({mc_done, mc_abort, exc_commit}), 64'h0);
  endtask

  int stall_seen;
  bit done_last;

  initial begin
    rst = 0;
    load_use_req = 0; branch_taken = 0; branch_target = 0; mc_start = 1;
    mem_wait = 0; exc_req = 1; eret_req = 0; epc_in = 32'h1234;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    mc_start = 0; exc_req = 0;
    #2 rst = 1;
    idle(2);

    // Load-use suppresses a simultaneous branch; branch alone next cycle.
    apply(1, 1, 32'h00400020, 0, 0, 0, 0, 32'h0);
    apply(0, 1, 32'h00400020, 0, 0, 0, 0, 32'h0);
    check_eq("branch_target", 64'(redirect_pc), 64'h00400020);

    // Divider op held for its full occupancy.
    stall_seen = 0;
    for (int i = 0; i < MC; i++) begin
      apply(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
      if (i < MC - 1 && stall_C == 4'hF) stall_seen++;
      done_last = mc_done && (stall_C == 4'h0);
    end
    check_eq("mc_stall_len", 64'(stall_seen), 64'(MC - 1));
    check_eq("mc_done_last", 64'(done_last), 64'h1);
    idle(2);

    // mem_wait overlapping the final counted cycle.
    for (int i = 0; i < MC + 3; i++)
      apply(0, 0, 32'h0, 1'(i < MC + 2), 1'(i >= MC - 2 && i < MC + 1), 0, 0, 32'h0);
    idle(1);

    // Exception mid-op at cnt=10, then a second one in the drain cycle.
    for (int i = 0; i < 21; i++) apply(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
    apply(0, 0, 32'h0, 1, 0, 1, 0, 32'h0);
    check_eq("abort_vector", 64'(redirect_pc), 64'(EXC_VEC));
    apply(0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
    check_eq("drain_ignore", 64'(exc_commit), 64'h0);
    idle(1);

    // ERET alone, then ERET with exception.
    apply(0, 0, 32'h0, 0, 0, 0, 1, 32'h00400100);
    check_eq("eret_pc", 64'(redirect_pc), 64'h00400100);
    idle(1);
    apply(0, 0, 32'h0, 0, 0, 1, 1, 32'h00400100);
    idle(2);

    // Asynchronous reset in the middle of an op.
    for (int i = 0; i < 10; i++) apply(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
    @(negedge clk);
    #2 rst = 0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    mc_start = 0;
    #2 rst = 1;
    idle(1);
    for (int i = 0; i < MC; i++) apply(0, 0, 32'h0, 1, 0, 0, 0, 32'h0);
    idle(1);
`ifdef PIPE_PERF_CNT_EN
    check_eq("perf_stall_31", 64'(stall_cycles), 64'(MC - 1));
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      apply(1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 30), $urandom,
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 20),
            1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 2), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
